// File: rtl/selector_pkg.sv
// selector_pkg: shared constants for the 4:1 gathering selector.
// Provides channel count, select width and mode encodings.
package selector_pkg;
    localparam int SEL_W = 2;
    localparam int N_CH  = 4;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [SEL_W-1:0] next_idx(
        input logic [SEL_W-1:0] idx
    );
        return idx + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: round-robin pick of the first set request starting at ptr.
// Ports: req[3:0], ptr[1:0] in; gnt_idx[1:0], gnt_any out.
module rr_pick4
    import selector_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);
    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the closest one to ptr wins.
    always_comb begin
        gnt_idx = ptr;
        idx     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
        gnt_any = |req;
    end
endmodule

// File: rtl/selector41_arb.sv
// selector41_arb: merges four valid/ready sources into one registered
// output, fixed select (iS1,iS0) or round-robin; 1-cycle latency.
// Ports: iClk, iRst_n, iMode, iS0, iS1, iC0..3, iV0..3, oR0..3,
//        oZ, oValid, iReady, oSel.
module selector41_arb
    import selector_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iMode,
    input  logic             iS0,
    input  logic             iS1,
    input  logic [WIDTH-1:0] iC0,
    input  logic [WIDTH-1:0] iC1,
    input  logic [WIDTH-1:0] iC2,
    input  logic [WIDTH-1:0] iC3,
    input  logic             iV0,
    input  logic             iV1,
    input  logic             iV2,
    input  logic             iV3,
    output logic             oR0,
    output logic             oR1,
    output logic             oR2,
    output logic             oR3,
    output logic [WIDTH-1:0] oZ,
    output logic             oValid,
    input  logic             iReady,
    output logic [SEL_W-1:0] oSel
);
    logic [N_CH-1:0]  req;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] fixed_idx;
    logic             fixed_any;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             load;
    logic             take;
    logic [N_CH-1:0]  rdy_vec;
    logic [WIDTH-1:0] gnt_data;

    assign req       = {iV3, iV2, iV1, iV0};
    assign fixed_idx = {iS1, iS0};
    assign fixed_any = req[fixed_idx];

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign gnt_idx = (iMode == MODE_RR) ? rr_idx : fixed_idx;
    assign gnt_any = (iMode == MODE_RR) ? rr_any : fixed_any;

    // Output register can accept when empty or draining this cycle.
    assign load = !oValid || iReady;
    // Gate with reset so no source sees ready while held in reset.
    assign take = load && gnt_any && iRst_n;

    always_comb begin
        rdy_vec = '0;
        if (take) begin
            rdy_vec[gnt_idx] = 1'b1;
        end
    end

    assign {oR3, oR2, oR1, oR0} = rdy_vec;

    always_comb begin
        unique case (gnt_idx)
            2'd0:    gnt_data = iC0;
            2'd1:    gnt_data = iC1;
            2'd2:    gnt_data = iC2;
            default: gnt_data = iC3;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oZ     <= '0;
            oValid <= 1'b0;
            oSel   <= '0;
            ptr    <= '0;
        end else if (take) begin
            oZ     <= gnt_data;
            oSel   <= gnt_idx;
            oValid <= 1'b1;
            if (iMode == MODE_RR) begin
                ptr <= next_idx(gnt_idx);
            end
        end else if (load) begin
            oValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_selector41_arb.sv
// tb_selector41_arb: random and directed stimulus against a behavioural
// model of the 4:1 selector, plus an in-order scoreboard of accepted words.
module tb_selector41_arb;
    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [1:0] s;
    logic [3:0] v;
    logic       rdy;
    logic [7:0] c [4];
    logic       r0, r1, r2, r3;
    logic [7:0] z;
    logic       ovalid;
    logic [1:0] osel;

    int vectors = 0;
    int fails   = 0;

    // behavioural model state
    int         m_ptr;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    logic [9:0] sb [$];

    selector41_arb #(.WIDTH(8)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iMode  (mode),
        .iS0    (s[0]),
        .iS1    (s[1]),
        .iC0    (c[0]),
        .iC1    (c[1]),
        .iC2    (c[2]),
        .iC3    (c[3]),
        .iV0    (v[0]),
        .iV1    (v[1]),
        .iV2    (v[2]),
        .iV3    (v[3]),
        .oR0    (r0),
        .oR1    (r1),
        .oR2    (r2),
        .oR3    (r3),
        .oZ     (z),
        .oValid (ovalid),
        .iReady (rdy),
        .oSel   (osel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Which source the model says is granted this cycle, -1 for none.
    function automatic int model_grant();
        int g;
        g = -1;
        if (m_valid && !rdy) return -1;
        if (mode == 1'b0) begin
            if (v[s]) g = int'(s);
        end else begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (v[k]) begin
                    g = k;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] rvec();
        return {r3, r2, r1, r0};
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 8'h00;
        m_sel   = 0;
        sb.delete();
    endtask

    // Runs one clock: checks readies and scoreboard before the edge,
    // advances the model, checks registered outputs after the edge.
    task automatic cycle();
        int g;
        logic [3:0] er;
        logic [9:0] e;
        #1;
        g  = model_grant();
        er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("ready", int'(rvec()), int'(er));
        if (ovalid && rdy) begin
            if (sb.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL sb_empty: got word %0h expected none", z);
            end else begin
                e = sb.pop_front();
                chk("sb_data", int'(z), int'(e[7:0]));
                chk("sb_sel", int'(osel), int'(e[9:8]));
            end
        end
        @(posedge clk);
        if (g >= 0) begin
            m_data  = c[g];
            m_sel   = g;
            m_valid = 1;
            if (mode) m_ptr = (g + 1) % 4;
            sb.push_back({2'(g), c[g]});
        end else if (!m_valid || rdy) begin
            m_valid = 0;
        end
        #1;
        chk("valid", int'(ovalid), int'(m_valid));
        chk("data", int'(z), int'(m_data));
        chk("sel", int'(osel), m_sel);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(ovalid), 0);
        chk("rst_data", int'(z), 0);
        chk("rst_sel", int'(osel), 0);
        chk("rst_ready", int'(rvec()), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic md, input logic [1:0] sl,
                         input logic [3:0] vv, input logic rd);
        mode = md;
        s    = sl;
        v    = vv;
        rdy  = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) c[i] = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // fixed select 2, channel 0 also valid but must be ignored
        c[0] = 8'h11;
        c[2] = 8'hA5;
        drive(1'b0, 2'b10, 4'b0101, 1'b1);
        #1;
        chk("t2_ready_lit", int'(rvec()), 4'b0100);
        cycle();
        chk("t2_data_lit", int'(z), 8'hA5);
        chk("t2_sel_lit", int'(osel), 2);
        chk("t2_valid_lit", int'(ovalid), 1);

        // backpressure: held word stays, nobody is ready
        c[2] = 8'h3C;
        drive(1'b0, 2'b10, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_hold_lit", int'(z), 8'hA5);
            chk("t5_rdy_lit", int'(rvec()), 0);
        end
        rdy = 1'b1;
        #1;
        chk("t5_resume_lit", int'(rvec()), 4'b0100);
        cycle();
        chk("t5_load_lit", int'(z), 8'h3C);

        // idle
        drive(1'b0, 2'b10, 4'b0000, 1'b1);
        cycle();
        chk("t6_idle_lit", int'(ovalid), 0);

        // round-robin rotation from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) c[i] = 8'(8'h40 + i);
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_seq_lit", int'(osel), i % 4);
        end

        // reset mid-stream while holding a word
        do_reset();
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        v = 4'b0010;
        cycle();
        chk("t4_grant_lit", int'(osel), 1);
        v = 4'b1111;
        cycle();
        chk("t4_ptr_lit", int'(osel), 2);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
            s   = 2'($urandom);
            v   = 4'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) c[i] = 8'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end
endmodule
